// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I pipeline types, including forwarding selects and shadow scoreboard slots.
package rv32i_types;
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } shadow_slot_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } ex_src_t;

    localparam shadow_slot_t SLOT_EMPTY = '0;

    function automatic logic writes_reg(shadow_slot_t s, logic [4:0] rs);
        return s.valid && s.regwrite && s.rd == rs;
    endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: picks the youngest in-flight producer of one EX operand.
module fwd_unit
    import rv32i_types::*;
(
    input  logic         use_rs,
    input  logic [4:0]   rs,
    input  shadow_slot_t mem_slot,
    input  shadow_slot_t wb_slot,
    output fwd_sel_t     sel
);
    logic unused;
    assign unused = mem_slot.is_load ^ wb_slot.is_load;
    always_comb begin
        sel = (!use_rs || rs == 5'd0) ? FWD_REG :
              writes_reg(mem_slot, rs) ? FWD_EXMEM :
              writes_reg(wb_slot, rs)  ? FWD_MEMWB : FWD_REG;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard priority, stage enables/flushes, shadow scoreboard, forwarding and perf counters.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_regwrite,
    input  logic        id_is_load,
    input  logic        ex_redirect,
    input  logic        imem_resp,
    input  logic        dmem_busy,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    shadow_slot_t ex_s, mem_s, wb_s, ex_nxt;
    ex_src_t      ex_src, src_nxt;
    fwd_sel_t     sel_a, sel_b;
    logic         redir, lu, miss, bubble;

    always_comb begin
        redir   = !dmem_busy && ex_redirect;
        lu      = !dmem_busy && !ex_redirect && id_valid && ex_s.valid && ex_s.is_load &&
                  ex_s.rd != 5'd0 && ((ex_s.rd == id_rs1 && id_use_rs1) || (ex_s.rd == id_rs2 && id_use_rs2));
        miss    = !dmem_busy && !ex_redirect && !lu && !imem_resp;
        bubble  = redir || lu || !id_valid;
        ex_nxt  = bubble ? SLOT_EMPTY : shadow_slot_t'({1'b1, id_rd, id_regwrite, id_is_load});
        src_nxt = bubble ? ex_src_t'('0) : ex_src_t'({id_rs1, id_rs2, id_use_rs1, id_use_rs2});
    end

    // Reset overrides everything so the datapath holds bubbles while rst is low.
    always_comb begin
        load_pc     = rst && !(dmem_busy || lu || miss);
        load_if_id  = rst && !(dmem_busy || lu);
        load_id_ex  = rst && !dmem_busy;
        load_ex_mem = rst && !dmem_busy;
        load_mem_wb = rst && !dmem_busy;
        flush_if_id = !rst || redir || miss;
        flush_id_ex = !rst || redir || lu;
        fwd_a       = rst ? sel_a : FWD_REG;
        fwd_b       = rst ? sel_b : FWD_REG;
    end

    fwd_unit u_fwd_a (
        .use_rs   (ex_s.valid && ex_src.use_rs1),
        .rs       (ex_src.rs1),
        .mem_slot (mem_s),
        .wb_slot  (wb_s),
        .sel      (sel_a)
    );

    fwd_unit u_fwd_b (
        .use_rs   (ex_s.valid && ex_src.use_rs2),
        .rs       (ex_src.rs2),
        .mem_slot (mem_s),
        .wb_slot  (wb_s),
        .sel      (sel_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_s         <= SLOT_EMPTY;
            mem_s        <= SLOT_EMPTY;
            wb_s         <= SLOT_EMPTY;
            ex_src       <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!dmem_busy) begin
                wb_s   <= mem_s;
                mem_s  <= ex_s;
                ex_s   <= ex_nxt;
                ex_src <= src_nxt;
            end
            if ((dmem_busy || lu || miss) && !(&stall_cycles))
                stall_cycles <= stall_cycles + 32'd1;
            if (redir && !(&flush_count))
                flush_count <= flush_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed test-plan scenarios plus randomized traffic against a queue-based reference model.
module tb_pipeline_ctrl;
    logic        clk = 1'b0, rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_redirect, imem_resp, dmem_busy;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles, flush_count;

    int total = 0, bad = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .imem_resp(imem_resp), .dmem_busy(dmem_busy),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
        .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd, rs1, rs2;
        bit       wr, ld, u1, u2;
    } ins_t;

    ins_t      pipe[$];
    bit [31:0] m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ins_t e;
        e = '{default: 0};
        pipe.delete();
        repeat (3) pipe.push_back(e);
        m_stall = 0;
        m_flush = 0;
    endtask

    function automatic int classify();
        if (dmem_busy) return 1;
        if (ex_redirect) return 2;
        if (id_valid && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
            ((pipe[0].rd == id_rs1 && id_use_rs1) || (pipe[0].rd == id_rs2 && id_use_rs2))) return 3;
        if (!imem_resp) return 4;
        return 5;
    endfunction

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    function automatic logic [6:0] ctl_of(int c);
        case (c)
            1:       return 7'b00000_00;
            2:       return 7'b11111_11;
            3:       return 7'b00111_01;
            4:       return 7'b01111_10;
            default: return 7'b11111_00;
        endcase
    endfunction

    // Nearest older writer of rs among MEM (1) and WB (2); 0 means register file.
    function automatic int fwd_of(bit u, bit [4:0] rs);
        if (!pipe[0].v || !u || rs == 0) return 0;
        for (int i = 1; i <= 2; i++)
            if (pipe[i].v && pipe[i].wr && pipe[i].rd == rs) return i;
        return 0;
    endfunction

    task automatic check_all();
        logic [6:0] e;
        e = ctl_of(classify());
        check("load_pc", 32'(load_pc), 32'(e[6]));
        check("load_if_id", 32'(load_if_id), 32'(e[5]));
        check("load_id_ex", 32'(load_id_ex), 32'(e[4]));
        check("load_ex_mem", 32'(load_ex_mem), 32'(e[3]));
        check("load_mem_wb", 32'(load_mem_wb), 32'(e[2]));
        check("flush_if_id", 32'(flush_if_id), 32'(e[1]));
        check("flush_id_ex", 32'(flush_id_ex), 32'(e[0]));
        check("fwd_a", 32'(fwd_a), 32'(fwd_of(pipe[0].u1, pipe[0].rs1)));
        check("fwd_b", 32'(fwd_b), 32'(fwd_of(pipe[0].u2, pipe[0].rs2)));
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
    endtask

    task automatic reset_checks();
        check("rst_load_pc", 32'(load_pc), 0);
        check("rst_loads", 32'({load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 0);
        check("rst_flushes", 32'({flush_if_id, flush_id_ex}), 3);
        check("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_flushcnt", flush_count, 0);
    endtask

    task automatic tick();
        int   c;
        ins_t n;
        c = classify();
        @(posedge clk);
        if (c != 1) begin
            n = '{default: 0};
            if (!(c == 2 || c == 3 || !id_valid)) begin
                n.v = 1; n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2;
                n.wr = id_regwrite; n.ld = id_is_load; n.u1 = id_use_rs1; n.u2 = id_use_rs2;
            end
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        if ((c == 1 || c == 3 || c == 4) && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (c == 2 && m_flush != 32'hFFFF_FFFF) m_flush++;
        #1;
    endtask

    task automatic set(input bit v, input bit [4:0] rs1, rs2, rd, input bit u1, u2, wr, ld, rdr, resp, busy);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = wr; id_is_load = ld;
        ex_redirect = rdr; imem_resp = resp; dmem_busy = busy;
    endtask

    task automatic step(input bit v, input bit [4:0] rs1, rs2, rd, input bit u1, u2, wr, ld, rdr, resp, busy);
        set(v, rs1, rs2, rd, u1, u2, wr, ld, rdr, resp, busy);
        #2;
        check_all();
        tick();
    endtask

    initial begin
        bit [31:0] s0, f0;
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b0;
        model_reset();
        #3 reset_checks();
        @(posedge clk);
        #1 rst = 1'b1;

        // lw x5 ; add x6,x5,x1
        step(1, 1, 0, 5, 1, 0, 1, 1, 0, 1, 0);
        set(1, 5, 1, 6, 1, 1, 1, 0, 0, 1, 0);
        #2 check_all();
        check("lu_load_pc", 32'(load_pc), 0);
        check("lu_flush_id_ex", 32'(flush_id_ex), 1);
        tick();
        step(1, 5, 1, 6, 1, 1, 1, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2 check_all();
        check("lu_fwd_a", 32'(fwd_a), 2);
        check("lu_stalls", stall_cycles, 1);
        tick();

        // add x3,x1,x2 ; sub x4,x3,x3
        step(1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 0);
        step(1, 3, 3, 4, 1, 1, 1, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2 check_all();
        check("raw_fwd_a", 32'(fwd_a), 1);
        check("raw_fwd_b", 32'(fwd_b), 1);
        tick();

        // single-cycle redirect
        f0 = flush_count;
        set(1, 1, 2, 7, 1, 1, 1, 0, 1, 1, 0);
        #2 check_all();
        check("redir_load_pc", 32'(load_pc), 1);
        tick();
        check("redir_count", flush_count, f0 + 1);

        // redirect held behind three busy cycles
        s0 = stall_cycles;
        f0 = flush_count;
        repeat (3) step(1, 1, 2, 8, 1, 1, 1, 0, 1, 1, 1);
        set(1, 1, 2, 8, 1, 1, 1, 0, 1, 1, 0);
        #2 check_all();
        check("rb_flush_if_id", 32'(flush_if_id), 1);
        tick();
        check("rb_stalls", stall_cycles, s0 + 3);
        check("rb_flushes", flush_count, f0 + 1);

        // lw x0 ; add reading x0
        step(1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0);
        set(1, 0, 0, 6, 1, 1, 1, 0, 0, 1, 0);
        #2 check_all();
        check("x0_load_pc", 32'(load_pc), 1);
        tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2 check_all();
        check("x0_fwd_a", 32'(fwd_a), 0);
        tick();

        // reset asserted during a load-use stall
        step(1, 1, 0, 7, 1, 0, 1, 1, 0, 1, 0);
        set(1, 7, 7, 9, 1, 1, 1, 0, 0, 1, 0);
        #2 check("pre_rst_load_pc", 32'(load_pc), 0);
        rst = 1'b0;
        #1 reset_checks();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2 check_all();
        check("post_rst_load_pc", 32'(load_pc), 1);
        tick();

        repeat (500) begin
            step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It tracks a shadow scoreboard of in-flight destination registers (EX/MEM/WB) and decides, every cycle, the load enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also produces the EX operand forwarding selects and two performance counters. It sits beside the datapath and consumes decode fields from ID, redirect from EX and memory handshakes from the cache ports.

## Interface
- No parameters.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: decoded register fields.
- `id_use_rs1`, `id_use_rs2`, `id_regwrite`, `id_is_load` in 1 each: from control ROM.
- `ex_redirect` in 1: EX resolved taken branch/jump (target driven to PC mux by datapath).
- `imem_resp` in 1: instruction fetch completes this cycle.
- `dmem_busy` in 1: MEM has an outstanding data access not responded this cycle.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: register enables.
- `flush_if_id`, `flush_id_ex` out 1 each: load a bubble (valid=0) instead of data.
- `fwd_a`, `fwd_b` out 2 each: `fwd_sel_t` — REG=0, EXMEM=1, MEMWB=2.
- `stall_cycles`, `flush_count` out 32 each: saturating perf counters.

## Operation
- Shadow slots EX, MEM, WB each hold {valid, rd, regwrite, is_load}; EX slot also holds rs1/rs2/use bits.
- Per-cycle priority, first match wins:
  1. `dmem_busy`: all `load_*` = 0, no flush, shadow frozen.
  2. `ex_redirect`: all `load_*` = 1, `flush_if_id` = `flush_id_ex` = 1, EX shadow slot loads invalid.
  3. Load-use: EX slot valid & is_load & rd≠0 & (rd==id_rs1 & id_use_rs1 | rd==id_rs2 & id_use_rs2) & id_valid. Result: `load_pc` = `load_if_id` = 0, `flush_id_ex` = 1, downstream enables = 1, EX slot loads invalid.
  4. `!imem_resp`: `load_pc` = 0, `flush_if_id` = 1, all other enables = 1.
  5. Else: all enables = 1, no flush.
- On any advance, shadow shifts EX→MEM→WB. EX slot captures ID fields, or invalid when bubbled or `id_valid`=0.
- Forwarding for EX slot rsN (use bit set, rsN≠0):
  - MEM slot valid & regwrite & rd match → EXMEM.
  - Else WB slot match → MEMWB.
  - Else REG.
  - x0 never forwards.
- `stall_cycles` +1 on cases 1, 3, 4; `flush_count` +1 on case 2. Both saturate at 0xFFFF_FFFF.

## Timing
- Enables, flushes and fwd selects are combinational from inputs and shadow state, valid in the same cycle. The shadow scoreboard and counters update on `posedge clk`.
- Load-use costs exactly 1 bubble. Redirect costs 2 bubbles (IF/ID + ID/EX).
- Redirect + dmem stall: stall wins. EX is frozen, so `ex_redirect` stays asserted and is honoured on the first non-busy cycle.
- Redirect + load-use or imem miss: redirect wins, no stall counted.
- Reset (`rst`=0, any time, asynchronous):
  - Shadow slots invalid; counters 0.
  - Outputs forced: `load_*` = 0, `flush_*` = 1, `fwd_*` = REG.
  - Normal operation resumes on the first edge after `rst` rises.

## Structure
- Add `fwd_sel_t` (2-bit enum) and a `shadow_slot_t` struct to the shared `rv32i_types` package.
- Forwarding compare is one natural combinational sub-module, `fwd_unit`, instantiated once per operand.
- Priority logic, shadow pipeline and counters stay in `pipeline_ctrl`.

## Test plan
- `lw x5` then `add x6,x5,x1` back-to-back → one cycle with `load_pc`=0 and `flush_id_ex`=1. Next cycle `fwd_a`=MEMWB; `stall_cycles`=1.
- `add x3,x1,x2` then `sub x4,x3,x3` → no stall; `fwd_a`=`fwd_b`=EXMEM while sub in EX.
- `ex_redirect` for 1 cycle → `flush_if_id`=`flush_id_ex`=1, `load_pc`=1; `flush_count` goes 0→1.
- `dmem_busy` held 3 cycles while `ex_redirect`=1 → all enables 0 for 3 cycles, then flush on cycle 4; `stall_cycles`=3, `flush_count`=1.
- Writer to x0 followed by reader of x0 → `fwd_a`=REG, no stall even if the writer is a load.
- Assert `rst`=0 mid-load-use stall → outputs immediately reset values. After release, the shadow is empty and the first instruction issues with no stall.
